// File: rtl/io_stage.sv
// io_stage: memory-access stage between EX and WB.
// Optional IO_STAGE_LOAD_FORWARD_EN: forward aligned load data to ID.
package io_stage_pkg;

  typedef struct packed {
    logic [31:0] program_count;
    logic        register_write;
    logic [4:0]  write_register;
    logic [31:0] alu_result;
    logic [1:0]  memory_address;
    logic        memory_io_unsigned;
    logic        load_byte;
    logic        load_half;
    logic        load_left;
    logic        load_right;
    logic        result_is_from_memory;
    logic        result_high;
    logic        result_low;
    logic        high_low_write;
    logic [31:0] source_register_data;
    logic [31:0] multi_use_register_data;
    logic        multiply_valid;
    logic [63:0] multiply_result;
    logic        divide_valid;
    logic        divide_result_valid;
    logic [31:0] divide_result;
    logic [31:0] divide_remain;
    logic        move_from_cp0;
    logic        move_to_cp0;
    logic [4:0]  destination_register;
    logic        exception_valid;
    logic        in_delay_slot;
    logic        eret_flush;
    logic [4:0]  exception_code;
    logic        is_address_fault;
    logic [31:0] badvaddr_value;
  } ex_to_io_bus_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] program_count;
    logic        register_write;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        move_from_cp0;
    logic        move_to_cp0;
    logic [4:0]  destination_register;
    logic [31:0] multi_use_register_data;
    logic        exception_valid;
    logic        in_delay_slot;
    logic        eret_flush;
    logic [4:0]  exception_code;
    logic        is_address_fault;
    logic [31:0] badvaddr_value;
  } io_to_wb_bus_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        data_valid;
  } ex_to_id_back_pass_bus_t;

endpackage

module io_stage
  import io_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ex_to_io_valid,
  input  ex_to_io_bus_t           ex_to_io_bus,
  output logic                    io_allow_in,
  input  logic [DATA_WIDTH-1:0]   data_ram_read_data,
  input  logic                    wb_allow_in,
  input  logic                    io_flush,
  output logic                    io_to_wb_valid,
  output io_to_wb_bus_t           io_to_wb_bus,
  output ex_to_id_back_pass_bus_t io_to_id_back_pass_bus,
  output logic                    io_to_ex_exception,
  output logic [DATA_WIDTH-1:0]   high_register,
  output logic [DATA_WIDTH-1:0]   low_register
);

  logic                  io_valid;
  ex_to_io_bus_t         io_bus;
  logic                  first_cycle;
  logic [DATA_WIDTH-1:0] held_data;
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;

  logic                  io_ready_go;
  logic                  accept;
  logic                  handoff;
  logic                  hilo_we;
  logic [31:0]           load_data;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           aligned;
  logic [31:0]           reg_result;
  logic [31:0]           result;

  assign io_ready_go = 1'b1;
  assign io_allow_in = !io_valid || (io_ready_go && wb_allow_in);
  assign accept      = io_allow_in && ex_to_io_valid;
  assign handoff     = io_valid && io_ready_go && wb_allow_in;
  assign hilo_we     = handoff && !io_flush
                    && !io_bus.exception_valid;

  // pipeline register and first-cycle read-data capture
  always_ff @(posedge clock) begin
    if (reset) begin
      io_valid    <= 1'b0;
      io_bus      <= '0;
      first_cycle <= 1'b0;
      held_data   <= '0;
    end else begin
      if (first_cycle)
        held_data <= data_ram_read_data;
      if (io_flush) begin
        io_valid    <= 1'b0;
        first_cycle <= 1'b0;
      end else begin
        first_cycle <= accept;
        if (io_allow_in)
          io_valid <= ex_to_io_valid;
        if (accept)
          io_bus <= ex_to_io_bus;
      end
    end
  end

  // HI/LO commit when the instruction leaves for WB
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_we) begin
      if (io_bus.multiply_valid) begin
        {hi_q, lo_q} <= io_bus.multiply_result;
      end else if (io_bus.divide_valid
                && io_bus.divide_result_valid) begin
        lo_q <= io_bus.divide_result;
        hi_q <= io_bus.divide_remain;
      end else if (io_bus.high_low_write) begin
        if (io_bus.result_high)
          hi_q <= io_bus.source_register_data;
        if (io_bus.result_low)
          lo_q <= io_bus.source_register_data;
      end
    end
  end

  // load alignment and sign/zero extension
  always_comb begin
    load_data = first_cycle ? data_ram_read_data
                            : held_data;
    ld_byte = load_data[7:0];
    unique case (io_bus.memory_address)
      2'd0: ld_byte = load_data[7:0];
      2'd1: ld_byte = load_data[15:8];
      2'd2: ld_byte = load_data[23:16];
      2'd3: ld_byte = load_data[31:24];
    endcase
    ld_half = io_bus.memory_address[1]
            ? load_data[31:16] : load_data[15:0];
    aligned = load_data;
    unique case (1'b1)
      io_bus.load_byte: begin
        if (io_bus.memory_io_unsigned)
          aligned = {24'b0, ld_byte};
        else
          aligned = {{24{ld_byte[7]}}, ld_byte};
      end
      io_bus.load_half: begin
        if (io_bus.memory_io_unsigned)
          aligned = {16'b0, ld_half};
        else
          aligned = {{16{ld_half[15]}}, ld_half};
      end
      io_bus.load_left: begin
        unique case (io_bus.memory_address)
          2'd0: aligned = {load_data[7:0],
            io_bus.multi_use_register_data[23:0]};
          2'd1: aligned = {load_data[15:0],
            io_bus.multi_use_register_data[15:0]};
          2'd2: aligned = {load_data[23:0],
            io_bus.multi_use_register_data[7:0]};
          2'd3: aligned = load_data;
        endcase
      end
      io_bus.load_right: begin
        unique case (io_bus.memory_address)
          2'd0: aligned = load_data;
          2'd1: aligned = {
            io_bus.multi_use_register_data[31:24],
            load_data[31:8]};
          2'd2: aligned = {
            io_bus.multi_use_register_data[31:16],
            load_data[31:16]};
          2'd3: aligned = {
            io_bus.multi_use_register_data[31:8],
            load_data[31:24]};
        endcase
      end
      default: aligned = load_data;
    endcase
  end

  // final result select: memory, HI, LO, then ALU
  always_comb begin
    reg_result = io_bus.alu_result;
    if (io_bus.result_high && !io_bus.high_low_write)
      reg_result = hi_q;
    else if (io_bus.result_low
          && !io_bus.high_low_write)
      reg_result = lo_q;
    result = io_bus.result_is_from_memory
           ? aligned : reg_result;
  end

  // WB bus, forwarding bus and exception hint
  always_comb begin
    io_to_wb_valid = io_valid;
    io_to_wb_bus = '0;
    io_to_wb_bus.valid = io_valid;
    io_to_wb_bus.program_count = io_bus.program_count;
    io_to_wb_bus.register_write =
      io_bus.register_write && !io_bus.exception_valid;
    io_to_wb_bus.write_register = io_bus.write_register;
    io_to_wb_bus.write_data = result;
    io_to_wb_bus.move_from_cp0 = io_bus.move_from_cp0;
    io_to_wb_bus.move_to_cp0 = io_bus.move_to_cp0;
    io_to_wb_bus.destination_register =
      io_bus.destination_register;
    io_to_wb_bus.multi_use_register_data =
      io_bus.multi_use_register_data;
    io_to_wb_bus.exception_valid = io_bus.exception_valid;
    io_to_wb_bus.in_delay_slot = io_bus.in_delay_slot;
    io_to_wb_bus.eret_flush = io_bus.eret_flush;
    io_to_wb_bus.exception_code = io_bus.exception_code;
    io_to_wb_bus.is_address_fault = io_bus.is_address_fault;
    io_to_wb_bus.badvaddr_value = io_bus.badvaddr_value;

    io_to_id_back_pass_bus = '0;
    io_to_id_back_pass_bus.valid = io_valid
      && io_bus.register_write
      && (io_bus.write_register != 5'd0);
    io_to_id_back_pass_bus.write_register =
      io_bus.write_register;
`ifdef IO_STAGE_LOAD_FORWARD_EN
    io_to_id_back_pass_bus.write_data = result;
    io_to_id_back_pass_bus.data_valid =
      !io_bus.move_from_cp0;
`else
    io_to_id_back_pass_bus.write_data = reg_result;
    io_to_id_back_pass_bus.data_valid =
      !io_bus.move_from_cp0
      && !io_bus.result_is_from_memory;
`endif

    io_to_ex_exception = io_valid
      && (io_bus.exception_valid || io_bus.eret_flush);
    high_register = hi_q;
    low_register  = lo_q;
  end

endmodule

// File: tb/tb_io_stage.sv
// tb_io_stage: random and directed checks of io_stage
// against a transaction-level model of the stage.
module tb_io_stage;
  import io_stage_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic ex_to_io_valid;
  ex_to_io_bus_t ex_to_io_bus;
  logic io_allow_in;
  logic [31:0] data_ram_read_data;
  logic wb_allow_in;
  logic io_flush;
  logic io_to_wb_valid;
  io_to_wb_bus_t io_to_wb_bus;
  ex_to_id_back_pass_bus_t bp;
  logic io_to_ex_exception;
  logic [31:0] high_register;
  logic [31:0] low_register;

  int total = 0;
  int bad = 0;

  // model: the instruction held in IO and its load word
  logic          m_valid;
  ex_to_io_bus_t m_bus;
  logic          m_pending;
  logic [31:0]   m_data;
  logic [31:0]   m_hi;
  logic [31:0]   m_lo;

  always #5 clock = ~clock;

  io_stage #(.DATA_WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .ex_to_io_valid(ex_to_io_valid),
    .ex_to_io_bus(ex_to_io_bus),
    .io_allow_in(io_allow_in),
    .data_ram_read_data(data_ram_read_data),
    .wb_allow_in(wb_allow_in),
    .io_flush(io_flush),
    .io_to_wb_valid(io_to_wb_valid),
    .io_to_wb_bus(io_to_wb_bus),
    .io_to_id_back_pass_bus(bp),
    .io_to_ex_exception(io_to_ex_exception),
    .high_register(high_register),
    .low_register(low_register)
  );

  task automatic chk(input string n,
                     input logic [255:0] a,
                     input logic [255:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, x);
    end
  endtask

  function automatic logic [31:0] m_load(
      input ex_to_io_bus_t b, input logic [31:0] d);
    int sh;
    logic [31:0] v;
    logic [31:0] rt;
    rt = b.multi_use_register_data;
    v = d;
    if (b.load_byte) begin
      sh = 8 * int'(b.memory_address);
      v = (d >> sh) & 32'hFF;
      if (!b.memory_io_unsigned && v[7])
        v = v | 32'hFFFFFF00;
    end else if (b.load_half) begin
      sh = 16 * int'(b.memory_address[1]);
      v = (d >> sh) & 32'hFFFF;
      if (!b.memory_io_unsigned && v[15])
        v = v | 32'hFFFF0000;
    end else if (b.load_left) begin
      sh = 8 * (3 - int'(b.memory_address));
      v = (d << sh) | (rt & ((32'h1 << sh) - 1));
    end else if (b.load_right) begin
      sh = 8 * int'(b.memory_address);
      v = (d >> sh) | (rt & ~(32'hFFFFFFFF >> sh));
    end
    return v;
  endfunction

  function automatic logic [31:0] m_result();
    logic [31:0] d;
    d = m_pending ? data_ram_read_data : m_data;
    if (m_bus.result_is_from_memory)
      return m_load(m_bus, d);
    if (m_bus.result_high && !m_bus.high_low_write)
      return m_hi;
    if (m_bus.result_low && !m_bus.high_low_write)
      return m_lo;
    return m_bus.alu_result;
  endfunction

  task automatic compare_all();
    io_to_wb_bus_t e;
    logic bpv;
    logic dv;
    chk("allow", 256'(io_allow_in),
        256'(!m_valid || wb_allow_in));
    chk("wb_valid", 256'(io_to_wb_valid), 256'(m_valid));
    chk("hi", 256'(high_register), 256'(m_hi));
    chk("lo", 256'(low_register), 256'(m_lo));
    chk("ex_exc", 256'(io_to_ex_exception),
        256'(m_valid && (m_bus.exception_valid
                      || m_bus.eret_flush)));
    bpv = m_valid && m_bus.register_write
       && (m_bus.write_register != 0);
    chk("bp_valid", 256'(bp.valid), 256'(bpv));
    if (m_valid) begin
      e = '0;
      e.valid = 1'b1;
      e.program_count = m_bus.program_count;
      e.register_write = m_bus.register_write
                      && !m_bus.exception_valid;
      e.write_register = m_bus.write_register;
      e.write_data = m_result();
      e.move_from_cp0 = m_bus.move_from_cp0;
      e.move_to_cp0 = m_bus.move_to_cp0;
      e.destination_register = m_bus.destination_register;
      e.multi_use_register_data =
        m_bus.multi_use_register_data;
      e.exception_valid = m_bus.exception_valid;
      e.in_delay_slot = m_bus.in_delay_slot;
      e.eret_flush = m_bus.eret_flush;
      e.exception_code = m_bus.exception_code;
      e.is_address_fault = m_bus.is_address_fault;
      e.badvaddr_value = m_bus.badvaddr_value;
      chk("wb_bus", 256'(io_to_wb_bus), 256'(e));
    end
    if (bpv) begin
`ifdef IO_STAGE_LOAD_FORWARD_EN
      dv = !m_bus.move_from_cp0;
`else
      dv = !m_bus.move_from_cp0
        && !m_bus.result_is_from_memory;
`endif
      chk("bp_dv", 256'(bp.data_valid), 256'(dv));
      chk("bp_reg", 256'(bp.write_register),
          256'(m_bus.write_register));
      if (dv)
        chk("bp_data", 256'(bp.write_data),
            256'(m_result()));
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_valid = 0; m_bus = '0; m_pending = 0;
      m_data = 0; m_hi = 0; m_lo = 0;
      return;
    end
    if (m_valid && wb_allow_in && !io_flush
        && !m_bus.exception_valid) begin
      if (m_bus.multiply_valid)
        {m_hi, m_lo} = m_bus.multiply_result;
      else if (m_bus.divide_valid
            && m_bus.divide_result_valid) begin
        m_lo = m_bus.divide_result;
        m_hi = m_bus.divide_remain;
      end else if (m_bus.high_low_write) begin
        if (m_bus.result_high)
          m_hi = m_bus.source_register_data;
        if (m_bus.result_low)
          m_lo = m_bus.source_register_data;
      end
    end
    if (m_pending) m_data = data_ram_read_data;
    m_pending = 0;
    if (io_flush) begin
      m_valid = 0;
    end else if (!m_valid || wb_allow_in) begin
      m_valid = ex_to_io_valid;
      if (ex_to_io_valid) begin
        m_bus = ex_to_io_bus;
        m_pending = 1;
      end
    end
  endtask

  task automatic put(input ex_to_io_bus_t b,
                     input logic v,
                     input logic [31:0] rd,
                     input logic wa,
                     input logic fl);
    ex_to_io_bus = b;
    ex_to_io_valid = v;
    data_ram_read_data = rd;
    wb_allow_in = wa;
    io_flush = fl;
    #1;
    compare_all();
  endtask

  task automatic advance();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  function automatic ex_to_io_bus_t mk_load(
      input int kind, input logic [1:0] a,
      input logic [31:0] rt, input logic uns);
    ex_to_io_bus_t b;
    b = '0;
    b.program_count = 32'hBFC0_0100;
    b.register_write = 1'b1;
    b.write_register = 5'd5;
    b.alu_result = {30'h40, a};
    b.memory_address = a;
    b.memory_io_unsigned = uns;
    b.result_is_from_memory = 1'b1;
    b.multi_use_register_data = rt;
    b.load_byte = (kind == 1);
    b.load_half = (kind == 2);
    b.load_left = (kind == 3);
    b.load_right = (kind == 4);
    return b;
  endfunction

  function automatic ex_to_io_bus_t rnd_bus();
    ex_to_io_bus_t b;
    b = '0;
    b.program_count = $urandom;
    b.alu_result = $urandom;
    b.multi_use_register_data = $urandom;
    b.source_register_data = $urandom;
    b.write_register = 5'($urandom);
    b.memory_address = 2'($urandom);
    b.memory_io_unsigned = 1'($urandom);
    b.register_write = 1'b1;
    b.move_to_cp0 = 1'($urandom);
    b.destination_register = 5'($urandom);
    b.in_delay_slot = 1'($urandom);
    b.exception_valid = ($urandom_range(0, 9) == 0);
    b.eret_flush = ($urandom_range(0, 19) == 0);
    b.exception_code = 5'($urandom);
    b.is_address_fault = 1'($urandom);
    b.badvaddr_value = $urandom;
    case ($urandom_range(0, 7))
      0: begin
        b.result_is_from_memory = 1'b1;
        case ($urandom_range(0, 4))
          1: b.load_byte = 1'b1;
          2: b.load_half = 1'b1;
          3: b.load_left = 1'b1;
          4: b.load_right = 1'b1;
          default: ;
        endcase
      end
      1: b.move_from_cp0 = ($urandom_range(0, 3) == 0);
      2: b.result_high = 1'b1;
      3: b.result_low = 1'b1;
      4: begin
        b.high_low_write = 1'b1;
        b.result_high = 1'b1;
        b.register_write = 1'b0;
      end
      5: begin
        b.high_low_write = 1'b1;
        b.result_low = 1'b1;
        b.register_write = 1'b0;
      end
      6: begin
        b.multiply_valid = 1'b1;
        b.multiply_result = {$urandom, $urandom};
        b.register_write = 1'b0;
      end
      default: begin
        b.divide_valid = 1'b1;
        b.divide_result_valid =
          ($urandom_range(0, 4) != 0);
        b.divide_result = $urandom;
        b.divide_remain = $urandom;
        b.register_write = 1'b0;
      end
    endcase
    return b;
  endfunction

  task automatic lit_load(input string n,
                          input ex_to_io_bus_t b,
                          input logic [31:0] rd,
                          input logic [31:0] x);
    put(b, 1, 0, 1, 0);
    advance();
    put('0, 0, rd, 1, 0);
    chk(n, 256'(io_to_wb_bus.write_data), 256'(x));
    advance();
  endtask

  initial begin
    ex_to_io_bus_t bm, bh, bd, be;
    logic exp_dv;
    reset = 1'b1;
    ex_to_io_valid = 0;
    ex_to_io_bus = '0;
    data_ram_read_data = 0;
    wb_allow_in = 0;
    io_flush = 0;
    m_valid = 0; m_bus = '0; m_pending = 0;
    m_data = 0; m_hi = 0; m_lo = 0;
    repeat (2) @(posedge clock);
    model_update();
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_wb_valid", 256'(io_to_wb_valid), 256'(0));
    chk("rst_bp_valid", 256'(bp.valid), 256'(0));
    chk("rst_allow", 256'(io_allow_in), 256'(1));
    chk("rst_hi", 256'(high_register), 256'(0));
    chk("rst_lo", 256'(low_register), 256'(0));
    @(negedge clock);

    put(mk_load(0, 2'd0, 0, 0), 1, 0, 1, 0);
    advance();
    put('0, 0, 32'hDEADBEEF, 1, 0);
    chk("lw_valid", 256'(io_to_wb_valid), 256'(1));
    chk("lw_data", 256'(io_to_wb_bus.write_data),
        256'(32'hDEADBEEF));
    advance();

    lit_load("lb", mk_load(1, 2'd3, 0, 0),
             32'h80112233, 32'hFFFFFF80);
    lit_load("lbu", mk_load(1, 2'd3, 0, 1),
             32'h80112233, 32'h00000080);
    lit_load("lh", mk_load(2, 2'd2, 0, 0),
             32'h80011234, 32'hFFFF8001);
    lit_load("lwl", mk_load(3, 2'd1, 32'h11223344, 0),
             32'hAABBCCDD, 32'hCCDD3344);
    lit_load("lwr", mk_load(4, 2'd2, 32'h11223344, 0),
             32'hAABBCCDD, 32'h1122AABB);

    put(mk_load(0, 2'd0, 0, 0), 1, 0, 1, 0);
    advance();
    put('0, 0, 32'h12345678, 0, 0);
    chk("stall_allow", 256'(io_allow_in), 256'(0));
    advance();
    for (int i = 0; i < 3; i++) begin
      put('0, 0, 0, 0, 0);
      chk("stall_data", 256'(io_to_wb_bus.write_data),
          256'(32'h12345678));
      chk("stall_allow", 256'(io_allow_in), 256'(0));
      advance();
    end
    put('0, 0, 0, 1, 0);
    advance();

    bm = '0;
    bm.multiply_valid = 1'b1;
    bm.multiply_result = 64'h00000001_FFFFFFFE;
    bh = '0;
    bh.register_write = 1'b1;
    bh.write_register = 5'd2;
    bh.result_high = 1'b1;
    bd = '0;
    bd.divide_valid = 1'b1;
    bd.divide_result_valid = 1'b1;
    bd.divide_result = 32'd7;
    bd.divide_remain = 32'd3;
    put(bm, 1, 0, 1, 0);
    advance();
    put(bh, 1, 0, 1, 0);
    advance();
    put(bd, 1, 0, 1, 0);
    chk("mfhi", 256'(io_to_wb_bus.write_data), 256'(1));
    chk("mult_hi", 256'(high_register), 256'(1));
    chk("mult_lo", 256'(low_register),
        256'(32'hFFFFFFFE));
    advance();
    put('0, 0, 0, 1, 1);
    advance();
    put('0, 0, 0, 1, 0);
    chk("flush_valid", 256'(io_to_wb_valid), 256'(0));
    chk("flush_hi", 256'(high_register), 256'(1));
    chk("flush_lo", 256'(low_register),
        256'(32'hFFFFFFFE));
    advance();

    be = mk_load(0, 2'd0, 0, 0);
    be.exception_valid = 1'b1;
    be.exception_code = 5'd4;
    put(be, 1, 0, 1, 0);
    advance();
    put('0, 0, 32'h55, 0, 0);
    chk("exc_sig", 256'(io_to_ex_exception), 256'(1));
    chk("exc_rw", 256'(io_to_wb_bus.register_write),
        256'(0));
    advance();
    put('0, 0, 0, 1, 1);
    advance();
    put(mk_load(0, 2'd0, 0, 0), 1, 0, 1, 0);
    advance();
`ifdef IO_STAGE_LOAD_FORWARD_EN
    exp_dv = 1'b1;
`else
    exp_dv = 1'b0;
`endif
    put('0, 0, 32'h66, 0, 0);
    chk("lw_bp_valid", 256'(bp.valid), 256'(1));
    chk("lw_bp_dv", 256'(bp.data_valid), 256'(exp_dv));
    advance();
    put('0, 0, 0, 1, 0);
    advance();

    for (int i = 0; i < 4000; i++) begin
      put(rnd_bus(),
          ($urandom_range(0, 3) != 0),
          $urandom,
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 15) == 0));
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
